// File: rtl/prll_bs_gnrtr_n_rbtr_wrap.sv
// rtl/prll_bs_gnrtr_n_rbtr_wrap.sv - round-robin shared-bus model with flat 2-driver / 1-bus wrapper

// Single-bus engine: pops one word from the round-robin winner, then pushes it to its destination(s).
module bs_arbtr #(
  parameter int         bits      = 32,
  parameter int         drvrs     = 2,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                        clk,
  input  logic                        i_rst,
  input  logic [drvrs-1:0]            i_pndng,
  input  logic [drvrs-1:0][bits-1:0]  i_d_pop,
  output logic [drvrs-1:0]            o_pop,
  output logic [drvrs-1:0]            o_push,
  output logic [bits-1:0]             o_d_bus
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    r_win;
  logic [PW-1:0]    w_win_nxt;
  logic [PW-1:0]    w_rr_win;
  logic             w_rr_found;
  logic [PW:0]      w_cand_sum;
  logic [PW-1:0]    w_cand;
  logic [drvrs-1:0] r_pop;
  logic [drvrs-1:0] r_push;
  logic [drvrs-1:0] w_pop_nxt;
  logic [drvrs-1:0] w_push_nxt;
  logic [drvrs-1:0] w_dest_hit;
  logic [bits-1:0]  r_bus;
  logic [bits-1:0]  w_bus_nxt;
  logic [7:0]       w_dest;

  assign w_dest = r_bus[bits-1 -: 8];

  // Round-robin search: first pending driver at or after the priority pointer, wrapping around.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    w_cand_sum = '0;
    w_cand     = '0;
    for (int k = 0; k < drvrs; k++) begin
      w_cand_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_cand_sum >= (PW+1)'(drvrs)) begin
        w_cand_sum = w_cand_sum - (PW+1)'(drvrs);
      end
      w_cand = w_cand_sum[PW-1:0];
      if (!w_rr_found && i_pndng[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_cand;
      end
    end
  end

  // Destination decode of the captured word; broadcast skips the driver that sourced it.
  always_comb begin
    w_dest_hit = '0;
    for (int j = 0; j < drvrs; j++) begin
      if (w_dest == 8'(j)) begin
        w_dest_hit[j] = 1'b1;
      end else if ((w_dest == broadcast) && (r_win != PW'(j))) begin
        w_dest_hit[j] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> POP -> PUSH transfer sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_bus_nxt   = r_bus;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_pop_nxt[w_rr_win] = 1'b1;
          w_bus_nxt           = i_d_pop[w_rr_win];
          w_win_nxt           = w_rr_win;
          w_ptr_nxt           = (w_rr_win == PW'(drvrs - 1)) ? '0 : w_rr_win + PW'(1);
          w_state_nxt         = S_POP;
        end
      end
      S_POP: begin
        w_push_nxt  = w_dest_hit;
        w_state_nxt = S_PUSH;
      end
      S_PUSH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered strobes, bus word, winner and priority pointer.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_pop  <= '0;
      r_push <= '0;
      r_bus  <= '0;
      r_win  <= '0;
      r_ptr  <= '0;
    end else begin
      r_pop  <= w_pop_nxt;
      r_push <= w_push_nxt;
      r_bus  <= w_bus_nxt;
      r_win  <= w_win_nxt;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign o_pop   = r_pop;
  assign o_push  = r_push;
  assign o_d_bus = r_bus;

endmodule

// Flat-port wrapper: two drivers on bus 0; any further buses have no drivers attached.
module prll_bs_gnrtr_n_rbtr_wrap #(
  parameter int         buses     = 1,
  parameter int         bits      = 32,
  parameter int         drvrs     = 2,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pndng_drvr_0_bus_0,
  input  logic            pndng_drvr_1_bus_0,
  input  logic [bits-1:0] D_pop_drvr_0_bus_0,
  input  logic [bits-1:0] D_pop_drvr_1_bus_0,
  output logic            pop_drvr_0_bus_0,
  output logic            pop_drvr_1_bus_0,
  output logic            push_drvr_0_bus_0,
  output logic            push_drvr_1_bus_0,
  output logic [bits-1:0] D_push_drvr_0_bus_0,
  output logic [bits-1:0] D_push_drvr_1_bus_0
);

  logic [buses-1:0][drvrs-1:0]            w_pndng;
  logic [buses-1:0][drvrs-1:0][bits-1:0]  w_d_pop;
  logic [buses-1:0][drvrs-1:0]            w_pop;
  logic [buses-1:0][drvrs-1:0]            w_push;
  logic [buses-1:0][bits-1:0]             w_d_bus;

  // Map the flat driver ports onto the bus/driver arrays; unattached slots stay idle.
  always_comb begin
    w_pndng       = '0;
    w_d_pop       = '0;
    w_pndng[0][0] = pndng_drvr_0_bus_0;
    w_pndng[0][1] = pndng_drvr_1_bus_0;
    w_d_pop[0][0] = D_pop_drvr_0_bus_0;
    w_d_pop[0][1] = D_pop_drvr_1_bus_0;
  end

  for (genvar b = 0; b < buses; b++) begin : g_bus
    bs_arbtr #(
      .bits      (bits),
      .drvrs     (drvrs),
      .broadcast (broadcast)
    ) u_arb (
      .clk     (clk),
      .i_rst   (reset),
      .i_pndng (w_pndng[b]),
      .i_d_pop (w_d_pop[b]),
      .o_pop   (w_pop[b]),
      .o_push  (w_push[b]),
      .o_d_bus (w_d_bus[b])
    );
  end

  assign pop_drvr_0_bus_0    = w_pop[0][0];
  assign pop_drvr_1_bus_0    = w_pop[0][1];
  assign push_drvr_0_bus_0   = w_push[0][0];
  assign push_drvr_1_bus_0   = w_push[0][1];
  assign D_push_drvr_0_bus_0 = w_d_bus[0];
  assign D_push_drvr_1_bus_0 = w_d_bus[0];

endmodule

// File: tb/tb_prll_bs_gnrtr_n_rbtr_wrap.sv
// tb/tb_prll_bs_gnrtr_n_rbtr_wrap.sv - directed self-checking bench for the shared-bus arbiter wrapper

module tb_prll_bs_gnrtr_n_rbtr_wrap;

  logic        clk;
  logic        reset;
  logic        pn0;
  logic        pn1;
  logic [31:0] dp0;
  logic [31:0] dp1;
  logic        pop0;
  logic        pop1;
  logic        push0;
  logic        push1;
  logic [31:0] dq0;
  logic [31:0] dq1;

  int n_tests = 0;
  int n_fail  = 0;

  prll_bs_gnrtr_n_rbtr_wrap #(1, 32, 2, 8'hFF) dut (
    .clk                 (clk),
    .reset               (reset),
    .pndng_drvr_0_bus_0  (pn0),
    .pndng_drvr_1_bus_0  (pn1),
    .D_pop_drvr_0_bus_0  (dp0),
    .D_pop_drvr_1_bus_0  (dp1),
    .pop_drvr_0_bus_0    (pop0),
    .pop_drvr_1_bus_0    (pop1),
    .push_drvr_0_bus_0   (push0),
    .push_drvr_1_bus_0   (push1),
    .D_push_drvr_0_bus_0 (dq0),
    .D_push_drvr_1_bus_0 (dq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle, then check pop/push vectors ({drv1,drv0}) and data of any pushed driver.
  task automatic cyc(input string tag, input logic [1:0] pop_e, input logic [1:0] push_e,
                     input logic [31:0] d_e);
    @(negedge clk);
    chk({tag, "_pop"},  {30'd0, pop1, pop0},   {30'd0, pop_e});
    chk({tag, "_push"}, {30'd0, push1, push0}, {30'd0, push_e});
    if (push_e[0]) chk({tag, "_d0"}, dq0, d_e);
    if (push_e[1]) chk({tag, "_d1"}, dq1, d_e);
  endtask

  initial begin
    reset = 1'b1;
    pn0   = 1'b0;
    pn1   = 1'b0;
    dp0   = '0;
    dp1   = '0;
    repeat (2) @(negedge clk);
    chk("init_pop",  {30'd0, pop1, pop0},   32'd0);
    chk("init_push", {30'd0, push1, push0}, 32'd0);
    chk("init_d0",   dq0, 32'd0);
    chk("init_d1",   dq1, 32'd0);

    // reset asserted mid-cycle with both drivers pending
    reset = 1'b0;
    pn0   = 1'b1;
    pn1   = 1'b1;
    dp0   = 32'h0100_0000;
    dp1   = 32'h0001_0000;
    cyc("rv_pre", 2'b01, 2'b00, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("rv_pop",  {30'd0, pop1, pop0},   32'd0);
    chk("rv_push", {30'd0, push1, push0}, 32'd0);
    chk("rv_d0",   dq0, 32'd0);
    chk("rv_d1",   dq1, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rv_hold_pop",  {30'd0, pop1, pop0},   32'd0);
      chk("rv_hold_push", {30'd0, push1, push0}, 32'd0);
      chk("rv_hold_d0",   dq0, 32'd0);
    end
    pn0   = 1'b0;
    pn1   = 1'b0;
    reset = 1'b0;
    cyc("rv_idle", 2'b00, 2'b00, 32'd0);

    // round-robin with both pending: grants 0,1,0,1
    pn0 = 1'b1;
    pn1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      if ((g % 2) == 0) begin
        cyc("rr0_pop",  2'b01, 2'b00, 32'd0);
        cyc("rr0_push", 2'b00, 2'b10, 32'h0100_0000);
      end else begin
        cyc("rr1_pop",  2'b10, 2'b00, 32'd0);
        cyc("rr1_push", 2'b00, 2'b01, 32'h0001_0000);
      end
      cyc("rr_gap", 2'b00, 2'b00, 32'd0);
    end
    pn0 = 1'b0;
    pn1 = 1'b0;
    cyc("rr_idle", 2'b00, 2'b00, 32'd0);

    // unicast 0 -> 1
    pn0 = 1'b1;
    dp0 = 32'h0100_0005;
    cyc("uc_pop", 2'b01, 2'b00, 32'd0);
    pn0 = 1'b0;
    cyc("uc_push", 2'b00, 2'b10, 32'h0100_0005);
    cyc("uc_end",  2'b00, 2'b00, 32'd0);
    cyc("uc_idle", 2'b00, 2'b00, 32'd0);
    chk("uc_hold", dq1, 32'h0100_0005);

    // broadcast from 0 reaches only driver 1
    pn0 = 1'b1;
    dp0 = 32'hFF00_0007;
    cyc("bc0_pop", 2'b01, 2'b00, 32'd0);
    pn0 = 1'b0;
    cyc("bc0_push", 2'b00, 2'b10, 32'hFF00_0007);
    cyc("bc0_end",  2'b00, 2'b00, 32'd0);

    // self-addressed word from 1 is delivered back to 1
    pn1 = 1'b1;
    dp1 = 32'h0101_0001;
    cyc("self_pop", 2'b10, 2'b00, 32'd0);
    pn1 = 1'b0;
    cyc("self_push", 2'b00, 2'b10, 32'h0101_0001);
    cyc("self_end",  2'b00, 2'b00, 32'd0);

    // broadcast from 1 reaches only driver 0
    pn1 = 1'b1;
    dp1 = 32'hFF01_0003;
    cyc("bc1_pop", 2'b10, 2'b00, 32'd0);
    pn1 = 1'b0;
    cyc("bc1_push", 2'b00, 2'b01, 32'hFF01_0003);
    cyc("bc1_end",  2'b00, 2'b00, 32'd0);

    // unknown destination is popped and dropped
    pn1 = 1'b1;
    dp1 = 32'h0501_0009;
    cyc("unk_pop", 2'b10, 2'b00, 32'd0);
    pn1 = 1'b0;
    cyc("unk_nopush", 2'b00, 2'b00, 32'd0);
    cyc("unk_end",    2'b00, 2'b00, 32'd0);
    cyc("unk_idle",   2'b00, 2'b00, 32'd0);
    chk("unk_bus", dq0, 32'h0501_0009);

    // reset during POP: no push follows; lone pending driver 1 then wins
    pn0 = 1'b1;
    dp0 = 32'h0100_00AA;
    cyc("mt_pop", 2'b01, 2'b00, 32'd0);
    pn0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mt_rst_pop", {30'd0, pop1, pop0}, 32'd0);
    chk("mt_rst_d1",  dq1, 32'd0);
    @(negedge clk);
    chk("mt_nopush", {30'd0, push1, push0}, 32'd0);
    pn1   = 1'b1;
    dp1   = 32'h0001_0022;
    reset = 1'b0;
    cyc("mt_pop1", 2'b10, 2'b00, 32'd0);
    pn1 = 1'b0;
    cyc("mt_push0", 2'b00, 2'b01, 32'h0001_0022);
    cyc("mt_end",   2'b00, 2'b00, 32'd0);

    // reset clears the pointer: grant 0 leaves it at 1, reset returns it to 0
    pn0 = 1'b1;
    dp0 = 32'h0100_00BB;
    cyc("pr_pop", 2'b01, 2'b00, 32'd0);
    pn0 = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    pn0   = 1'b1;
    pn1   = 1'b1;
    dp1   = 32'h0001_0044;
    reset = 1'b0;
    cyc("pr_first", 2'b01, 2'b00, 32'd0);
    pn0 = 1'b0;
    pn1 = 1'b0;
    cyc("pr_push", 2'b00, 2'b10, 32'h0100_00BB);
    cyc("pr_end",  2'b00, 2'b00, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prll_bs_gnrtr_n_rbtr_wrap.md
# prll_bs_gnrtr_n_rbtr_wrap

Parallel shared-bus model with a round-robin arbiter, wrapped with flat per-driver ports for 2 drivers on 1 bus. Each driver exposes a FIFO-style interface. The arbiter pops one pending word from a single driver, then places it on the bus. The word is pushed into the driver selected by the destination byte, or into all other drivers on a broadcast. The block sits between the driver FIFOs of the bus-test system and the system-level bench.

## Interface
- `buses`, default 1: number of buses. The wrapper port list is fixed at 1.
- `bits`, default 32: word width. Must be ≥ 8.
- `drvrs`, default 2: number of drivers. The wrapper port list is fixed at 2.
- `broadcast`, default 8'hFF: destination value meaning "all drivers".
- Positional parameter order: buses, bits, drvrs, broadcast.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pndng_drvr_0_bus_0`, `pndng_drvr_1_bus_0` input 1: driver i has a word waiting.
- `D_pop_drvr_0_bus_0`, `D_pop_drvr_1_bus_0` input bits: head word of driver i. Valid while pndng is high.
- `pop_drvr_0_bus_0`, `pop_drvr_1_bus_0` output 1: one-cycle pop strobe to driver i.
- `push_drvr_0_bus_0`, `push_drvr_1_bus_0` output 1: one-cycle push strobe to driver i.
- `D_push_drvr_0_bus_0`, `D_push_drvr_1_bus_0` output bits: bus word delivered to driver i. Meaningful while push is high.

## Operation
- Word format:
  - [bits-1:bits-8] destination driver id
  - [bits-9:bits-16] source id (carried, not interpreted)
  - remainder is payload
- All outputs are registered.
- States: IDLE → POP → PUSH → IDLE.
- IDLE:
  - If any pndng is high, select winner w by round-robin.
  - Assert pop_w; latch D_pop_w into bus register; go to POP.
  - Otherwise stay in IDLE with all strobes low.
- POP:
  - Deassert pop.
  - Decode the destination byte of the bus register. Assert push_j for every matching driver j; go to PUSH.
- Destination rules:
  - dest == j (0 or 1): push_j only. Self-addressed words (dest == w) are delivered to w.
  - dest == broadcast: push to every driver j ≠ w.
  - Any other value: no push; the word is dropped (the pop still occurred).
- PUSH: deassert all pushes; go to IDLE.
- D_push_drvr_j_bus_0 continuously drives the bus register for every j. The value holds until the next capture.
- Round-robin:
  - Priority pointer starts at driver 0.
  - After granting w, the pointer moves to (w+1) mod drvrs.
  - If only one driver is pending, it wins regardless of the pointer.
- pndng is sampled only in IDLE. Changes during POP or PUSH are ignored.

## Timing
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE.
  - All pop and push outputs go to 0.
  - Bus register and all D_push go to 0.
  - Pointer goes to driver 0.
- The transfer in flight is abandoned. A word already popped is lost.
- Latency:
  - Edge k (IDLE, pndng seen): pop high during cycle k→k+1.
  - Edge k+1: push high during cycle k+1→k+2, with D_push = popped word.
  - Edge k+2: strobes low.
  - Edge k+3: next arbitration.
- Throughput: at most one word per 3 clock cycles.
- pop and push are never high in the same cycle.
- At most one pop is high in any cycle.
- A driver must update pndng and D_pop within 2 cycles after its pop. The next sampling occurs at edge k+3.

## Test plan
- **Reset values:** assert reset mid-cycle with both pndng=1. All pop/push/D_push go to 0 immediately and remain 0 while reset is high.
- **Unicast 0→1:** pndng_0=1, D_pop_0=32'h0100_0005. Expect pop_0 for one cycle, then push_1 for one cycle with D_push_1=32'h0100_0005. push_0 stays 0.
- **Round-robin:** both pndng held at 1.
  - D_pop_0=32'h0100_0000, D_pop_1=32'h0001_0000.
  - Pops alternate 0,1,0,1, one grant every 3 cycles.
  - Pushes alternate push_1 (32'h0100_0000) and push_0 (32'h0001_0000).
- **Broadcast:** pndng_0=1, D_pop_0=32'hFF00_0007. Expect pop_0, then push_1 only, with D_push_1=32'hFF00_0007.
- **Unknown destination:** pndng_1=1, D_pop_1=32'h0501_0009. Expect pop_1, no push, then return to IDLE.
- **Reset mid-transfer:** assert reset in the POP cycle. No push follows. After release with pndng_1=1, the first grant goes to driver 1 (only one pending), and the pointer restarts from 0.
